// File: rtl/eth_pkt_pkg.sv
// eth_pkt_pkg: shared encodings for the GMII receive packer and its consumers.
//   - FIFO word flag encodings (bits [17:16] of the 18-bit word)
//   - receiver state encodings
//   - header geometry (word count, pad value) and skid buffer depth
//   - hdr_word(): selects the header word for a given index
package eth_pkt_pkg;

  localparam logic [1:0] FLG_PAIR = 2'b11;  // two valid bytes
  localparam logic [1:0] FLG_ONE  = 2'b10;  // one valid byte in [15:8]
  localparam logic [1:0] FLG_TERM = 2'b00;  // frame terminator

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PREAMBLE = 3'd1;
  localparam logic [2:0] ST_HEAD     = 3'd2;
  localparam logic [2:0] ST_DATA     = 3'd3;
  localparam logic [2:0] ST_TERM     = 3'd4;
  localparam logic [2:0] ST_DROP     = 3'd5;

  localparam int          HDR_WORDS  = 5;
  localparam logic [15:0] HDR_PAD    = 16'h0000;
  localparam int          SKID_DEPTH = 6;

  localparam logic [7:0] PRE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;

  // Header is the timestamp MSW first, followed by one pad word.
  function automatic logic [15:0] hdr_word(input logic [63:0] ts, input logic [2:0] idx);
    case (idx)
      3'd0:    hdr_word = ts[63:48];
      3'd1:    hdr_word = ts[47:32];
      3'd2:    hdr_word = ts[31:16];
      3'd3:    hdr_word = ts[15:0];
      default: hdr_word = HDR_PAD;
    endcase
  endfunction

endpackage

// File: rtl/bin2gray.sv
// bin2gray: combinational binary-to-Gray converter.
//   bin  in  W  binary value
//   gray out W  reflected Gray code of bin
module bin2gray #(
  parameter int W = 8
) (
  input  logic [W-1:0] bin,
  output logic [W-1:0] gray
);
  assign gray = bin ^ (bin >> 1);
endmodule

// File: rtl/gmii_rx_packer.sv
// gmii_rx_packer: strips preamble/SFD from a GMII receive stream and packs
// frame bytes into 18-bit FIFO words: a 5-word timestamp header, byte pairs,
// an optional single-byte tail word and a terminator carrying {ovf, err}.
//   gmii_rx_clk     in   clock, rising edge
//   sys_rst         in   async active-low reset
//   gmii_rx_dv/er   in   GMII data valid / error
//   gmii_rxd        in   GMII byte
//   global_counter  in   timestamp, latched at SFD
//   phy_din         out  FIFO word {flags, byte0, byte1}
//   phy_full        in   FIFO full
//   phy_wr_en       out  FIFO write strobe
//   phy_rx_count    out  Gray-coded terminated-frame count
module gmii_rx_packer
  import eth_pkt_pkg::*;
#(
  parameter int MAX_BYTES = 2040
) (
  input  logic        gmii_rx_clk,
  input  logic        sys_rst,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  input  logic [7:0]  gmii_rxd,
  input  logic [63:0] global_counter,
  output logic [17:0] phy_din,
  input  logic        phy_full,
  output logic        phy_wr_en,
  output logic [7:0]  phy_rx_count
);

  localparam logic [10:0] MAX_CNT = 11'(MAX_BYTES);

  logic [2:0]                  state_q, state_d;
  logic [2:0]                  hdr_idx_q, hdr_idx_d;
  logic [63:0]                 ts_q, ts_d;
  logic                        err_q, err_d;
  logic                        ovf_q, ovf_d;
  logic                        eof_q, eof_d;    // dv has fallen for this frame
  logic [10:0]                 bcnt_q, bcnt_d;
  logic [SKID_DEPTH-1:0][7:0]  skid_q, skid_d;
  logic [2:0]                  lvl_q, lvl_d;
  logic [7:0]                  rx_cnt_q, rx_cnt_d;
  logic [7:0]                  rx_gray_q, rx_gray_d;

  logic        wr_en;
  logic [17:0] din;
  logic        in_frame, live, ended, pop;

  always_comb begin
    state_d   = state_q;
    hdr_idx_d = hdr_idx_q;
    ts_d      = ts_q;
    err_d     = err_q;
    ovf_d     = ovf_q;
    eof_d     = eof_q;
    bcnt_d    = bcnt_q;
    skid_d    = skid_q;
    lvl_d     = lvl_q;
    rx_cnt_d  = rx_cnt_q;
    wr_en     = 1'b0;
    din       = '0;
    pop       = 1'b0;

    in_frame = (state_q == ST_HEAD) || (state_q == ST_DATA);
    // Once dv drops, later dv activity belongs to the next frame.
    live  = in_frame && gmii_rx_dv && !eof_q;
    ended = eof_q || !gmii_rx_dv;
    if (in_frame && !gmii_rx_dv) eof_d = 1'b1;
    if (live && gmii_rx_er)      err_d = 1'b1;

    case (state_q)
      ST_IDLE: if (gmii_rx_dv) state_d = ST_PREAMBLE;
      ST_PREAMBLE: begin
        if (!gmii_rx_dv) state_d = ST_IDLE;
        else if (gmii_rxd == PRE_BYTE) state_d = ST_PREAMBLE;
        else if (gmii_rxd == SFD_BYTE && !phy_full) begin
          state_d   = ST_HEAD;
          ts_d      = global_counter;
          hdr_idx_d = '0;
          err_d     = 1'b0;
          ovf_d     = 1'b0;
          eof_d     = 1'b0;
          bcnt_d    = '0;
          lvl_d     = '0;
        end else state_d = ST_DROP;
      end
      ST_HEAD: begin
        if (phy_full) begin
          // Header cannot complete; the DATA state discards in ovf mode.
          ovf_d   = 1'b1;
          state_d = ST_DATA;
        end else begin
          wr_en     = 1'b1;
          din       = {FLG_PAIR, hdr_word(ts_q, hdr_idx_q)};
          hdr_idx_d = hdr_idx_q + 3'd1;
          if (hdr_idx_q == 3'(HDR_WORDS - 1)) state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (ovf_q) begin
          if (ended) state_d = ST_TERM;
        end else if (phy_full) begin
          ovf_d = 1'b1;
        end else if (lvl_q >= 3'd2) begin
          wr_en = 1'b1;
          din   = {FLG_PAIR, skid_q[0], skid_q[1]};
          pop   = 1'b1;
        end else if (ended) begin
          if (lvl_q == 3'd1) begin
            wr_en = 1'b1;
            din   = {FLG_ONE, skid_q[0], 8'h00};
          end
          state_d = ST_TERM;
        end
      end
      ST_TERM: begin
        lvl_d = '0;
        if (!phy_full) begin
          wr_en    = 1'b1;
          din      = {FLG_TERM, 14'h0, ovf_q, err_q};
          rx_cnt_d = rx_cnt_q + 8'd1;
          state_d  = ST_IDLE;
        end
      end
      ST_DROP: if (!gmii_rx_dv) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (pop) begin
      for (int i = 0; i < SKID_DEPTH - 2; i++) skid_d[i] = skid_q[i+2];
      skid_d[SKID_DEPTH-1] = '0;
      skid_d[SKID_DEPTH-2] = '0;
      lvl_d = lvl_q - 3'd2;
    end

    // Bytes are stored until the length limit; past it the frame is truncated.
    if (live && !ovf_d) begin
      if (bcnt_q >= MAX_CNT) ovf_d = 1'b1;
      else begin
        for (int i = 0; i < SKID_DEPTH; i++)
          if (3'(i) == lvl_d) skid_d[i] = gmii_rxd;
        lvl_d = lvl_d + 3'd1;
        if (bcnt_q != 11'h7FF) bcnt_d = bcnt_q + 11'd1;
      end
    end
  end

  // Gray value is registered so the other domain never samples a glitch.
  bin2gray #(.W(8)) u_bin2gray (.bin(rx_cnt_d), .gray(rx_gray_d));

  always_ff @(posedge gmii_rx_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q   <= ST_IDLE;
      hdr_idx_q <= '0;
      ts_q      <= '0;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
      eof_q     <= 1'b0;
      bcnt_q    <= '0;
      skid_q    <= '0;
      lvl_q     <= '0;
      rx_cnt_q  <= '0;
      rx_gray_q <= '0;
    end else begin
      state_q   <= state_d;
      hdr_idx_q <= hdr_idx_d;
      ts_q      <= ts_d;
      err_q     <= err_d;
      ovf_q     <= ovf_d;
      eof_q     <= eof_d;
      bcnt_q    <= bcnt_d;
      skid_q    <= skid_d;
      lvl_q     <= lvl_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_gray_q <= rx_gray_d;
    end
  end

  // Write strobe is combinational so it can never outlive phy_full rising.
  assign phy_wr_en    = wr_en;
  assign phy_din      = din;
  assign phy_rx_count = rx_gray_q;

endmodule
